// File: rtl/spi_pkg.sv
// Shared constants for the SPI-to-register-bus transaction layer.
// Holds default widths, command/status bit positions and FSM state encodings.
// Imported by spi_reg_bridge; no logic lives here.
package spi_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = DEF_DATA_WIDTH - 1;

    // Command byte: MSB selects read (1) or write (0), low bits carry the start address.
    localparam int CMD_RW_BIT          = DEF_DATA_WIDTH - 1;
    // Status byte shifted out during the command byte: MSB reports underrun.
    localparam int STATUS_UNDERRUN_BIT = DEF_DATA_WIDTH - 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WR_STREAM = 2'd1;
    localparam logic [1:0] ST_RD_FETCH  = 2'd2;
    localparam logic [1:0] ST_RD_STREAM = 2'd3;

endpackage

// File: rtl/spi_reg_bridge.sv
// Purpose: turns SPI chip-select frames into register-bus reads/writes (cmd byte, then data with auto-increment).
// Latency: bus_we/bus_re one cycle after rx_wr_req; tx_byte loads one cycle after bus_rvalid.
// Backpressure: none toward SPI; a read fetch still outstanding at rx_rd_req sets the sticky underrun flag.
//
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   chip_select_n           - SPI frame select (high aborts the frame)
//   rx_wr_req, rx_byte      - received-byte strobe and byte from the SPI slave
//   rx_rd_req, tx_byte      - SPI slave load strobe and the registered byte it loads
//   bus_addr/wdata/we/re    - register-bus request side (all registered)
//   bus_rdata, bus_rvalid   - register-bus read return
//   underrun                - sticky flag, reported in the status byte MSB
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  chip_select_n,
    input  logic                  rx_wr_req,
    input  logic                  rx_rd_req,
    input  logic [DATA_WIDTH-1:0] rx_byte,
    output logic [DATA_WIDTH-1:0] tx_byte,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic                  bus_we,
    output logic                  bus_re,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_rvalid,
    output logic                  underrun
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [1:0]            state_q,     state_d;
    logic [DATA_WIDTH-1:0] tx_byte_q,   tx_byte_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                  bus_we_q,    bus_we_d;
    logic                  bus_re_q,    bus_re_d;
    logic                  underrun_q,  underrun_d;
    // A read abandoned by chip-select still owes one bus_rvalid; swallow it so it
    // cannot be mistaken for the answer to a later frame's fetch.
    logic                  orphan_q,    orphan_d;

    logic [DATA_WIDTH-1:0] status_byte;
    logic                  rvalid_ok;

    always_comb begin
        status_byte = '0;
        status_byte[STATUS_UNDERRUN_BIT] = underrun_q;
    end

    assign rvalid_ok = bus_rvalid && !orphan_q;

    always_comb begin
        state_d     = state_q;
        tx_byte_d   = tx_byte_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = 1'b0;
        bus_re_d    = 1'b0;
        underrun_d  = underrun_q;
        orphan_d    = orphan_q && !bus_rvalid;

        // Address advances the cycle after a write strobe, even if the frame just ended.
        if (AUTO_INC && bus_we_q) begin
            bus_addr_d = bus_addr_q + ADDR_ONE;
        end

        if (chip_select_n) begin
            state_d   = ST_IDLE;
            tx_byte_d = status_byte;
            if (state_q == ST_RD_FETCH && !bus_rvalid) begin
                orphan_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_byte_d = status_byte;
                    if (rx_wr_req) begin
                        bus_addr_d = rx_byte[ADDR_WIDTH-1:0];
                        // The status byte carrying the flag has just been shifted out.
                        if (tx_byte_q[STATUS_UNDERRUN_BIT]) begin
                            underrun_d = 1'b0;
                        end
                        if (rx_byte[CMD_RW_BIT]) begin
                            bus_re_d  = 1'b1;
                            tx_byte_d = tx_byte_q;
                            state_d   = ST_RD_FETCH;
                        end else begin
                            tx_byte_d = '0;
                            state_d   = ST_WR_STREAM;
                        end
                    end
                end
                ST_WR_STREAM: begin
                    tx_byte_d = '0;
                    if (rx_wr_req) begin
                        bus_wdata_d = rx_byte;
                        bus_we_d    = 1'b1;
                    end
                end
                ST_RD_FETCH: begin
                    if (rx_rd_req) begin
                        underrun_d = 1'b1;
                    end
                    if (rvalid_ok) begin
                        tx_byte_d = bus_rdata;
                        state_d   = ST_RD_STREAM;
                        // Dummy byte landing with the data: capture first, then prefetch next.
                        if (rx_wr_req) begin
                            if (AUTO_INC) begin
                                bus_addr_d = bus_addr_q + ADDR_ONE;
                            end
                            bus_re_d = 1'b1;
                            state_d  = ST_RD_FETCH;
                        end
                    end
                end
                default: begin // ST_RD_STREAM
                    if (rx_wr_req) begin
                        if (AUTO_INC) begin
                            bus_addr_d = bus_addr_q + ADDR_ONE;
                        end
                        bus_re_d = 1'b1;
                        state_d  = ST_RD_FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            tx_byte_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            bus_re_q    <= 1'b0;
            underrun_q  <= 1'b0;
            orphan_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_byte_q   <= tx_byte_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            bus_re_q    <= bus_re_d;
            underrun_q  <= underrun_d;
            orphan_q    <= orphan_d;
        end
    end

    assign tx_byte   = tx_byte_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;
    assign bus_re    = bus_re_q;
    assign underrun  = underrun_q;

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Transaction layer directly downstream of the SPI slave shift stage.
- Consumes its received-byte strobe (wr_req) and parallel byte, and supplies the next byte to shift out (tx_byte, sampled by SPI on rd_req).
- Turns each chip-select frame into register-bus reads or writes: byte 0 is the command, later bytes are data with address auto-increment.
- Sits between the SPI slave and the control register bank.

Parameters:
- DATA_WIDTH, 8, byte width; must equal SPI_BUS_WIDTH of the SPI slave.
- ADDR_WIDTH, 7, register address width; fixed at DATA_WIDTH-1.
- AUTO_INC, 1, 1 = increment address after each data byte; 0 = hold address.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- chip_select_n  input  1  SPI frame select, active low, same signal that drives the SPI slave
- rx_wr_req  input  1  one-cycle pulse: rx_byte holds a completed received byte
- rx_rd_req  input  1  one-cycle pulse: SPI slave is loading tx_byte into its shift register this cycle
- rx_byte  input  DATA_WIDTH  received byte from the SPI slave
- tx_byte  output  DATA_WIDTH  next byte to transmit, registered
- bus_addr  output  ADDR_WIDTH  register address, registered
- bus_wdata  output  DATA_WIDTH  write data, registered
- bus_we  output  1  one-cycle write strobe
- bus_re  output  1  one-cycle read strobe
- bus_rdata  input  DATA_WIDTH  read data, qualified by bus_rvalid
- bus_rvalid  input  1  read data valid, 1..3 cycles after bus_re
- underrun  output  1  sticky flag: rx_rd_req arrived while a read fetch was outstanding

Behaviour:
- Reset, asynchronous: state=IDLE; tx_byte=0; bus_addr=0; bus_wdata=0; bus_we=0; bus_re=0; underrun=0.
- Command byte format: bit[DATA_WIDTH-1] is R/W (1 = read); bits[ADDR_WIDTH-1:0] are the start address.
- States: IDLE, WR_STREAM, RD_FETCH, RD_STREAM.
- IDLE: on the first rx_wr_req of a frame, latch the address into bus_addr.
  - Write command: go to WR_STREAM.
  - Read command: pulse bus_re the next cycle, go to RD_FETCH.
  - While in IDLE, tx_byte = {underrun, {DATA_WIDTH-1{0}}}; this is the status byte shifted out during the command byte.
- WR_STREAM: on rx_wr_req, bus_wdata<=rx_byte and bus_we=1 for exactly one cycle with the current bus_addr.
  - bus_addr increments the cycle after bus_we when AUTO_INC=1.
  - rx_rd_req is ignored; tx_byte holds 0.
- RD_FETCH: wait for bus_rvalid, then tx_byte<=bus_rdata and go to RD_STREAM.
  - Required latency: bus_re to tx_byte valid is at most 4 clk, which fits before the following rx_rd_req.
- RD_STREAM: on rx_wr_req (a dummy byte received, content ignored), increment bus_addr if AUTO_INC, pulse bus_re, go to RD_FETCH.
- rx_rd_req while in RD_FETCH: set underrun=1; tx_byte keeps its stale value.
  - underrun clears only on reset, or when a frame's command byte is received while the flag is already being reported.
- Address wrap: bus_addr increments modulo 2^ADDR_WIDTH, so 0x7F -> 0x00.
- Simultaneous events:
  - rx_wr_req and bus_rvalid in the same cycle: capture rdata first, then process the request in the same cycle; the next bus_re is issued the following cycle.
  - rx_wr_req and rx_rd_req in the same cycle are illegal from the SPI slave and need not be handled.
- chip_select_n high, any state: return to IDLE next cycle; bus_we/bus_re forced 0; a pending read is abandoned and a late bus_rvalid is ignored.
  - A write already strobed completes; a byte not yet strobed is dropped.
- bus_we and bus_re are never asserted together. At most one read is outstanding.

Decomposition:
- Shared package (spi_pkg): DATA_WIDTH/ADDR_WIDTH defaults, CMD_RW_BIT index, state encoding constants, STATUS_UNDERRUN_BIT.
- Single module; no sub-module needed. The address counter is inline.

Test Plan:
- Write burst: frame 0x05, 0x11, 0x22, 0x33 (R/W=0, addr 0x05) -> bus_we at addr 0x05/0x06/0x07 with data 0x11/0x22/0x33, exactly 3 strobes.
- Read burst: frame 0x8A plus 2 dummies, bus returns 0xC1@0x0A and 0xC2@0x0B with 2-cycle latency -> tx_byte=0xC1 before 1st rx_rd_req, 0xC2 before 2nd; bus_re at addr 0x0A, then 0x0B, then 0x0C (third prefetch discarded at CS high).
- Wrap: write frame 0x7F, 0xAA, 0xBB -> writes at 0x7F then 0x00.
- Underrun: bus_rvalid delayed 20 cycles, rx_rd_req arrives during fetch -> underrun=1; next frame's first shifted byte is 0x80.
- Abort: chip_select_n rises during RD_FETCH, late bus_rvalid arrives -> state IDLE, tx_byte unchanged by the rdata, no further bus_re.
- Reset mid-write: reset_n low one cycle after rx_wr_req in WR_STREAM -> all outputs 0 immediately; no bus_we afterward.
